// File: rtl/mem_stage_lsu_pkg.sv
// Shared LSU types and RV32I load/store func3 codes.
// Imported by mem_stage_lsu and lsu_lane_align.
package definitions;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsuState_t;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } memWidth_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic memWidth_t f3_width(
    input logic [2:0] f3
  );
    memWidth_t w;
    unique case (f3[1:0])
      2'b00:   w = BYTE;
      2'b01:   w = HALF;
      default: w = WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering: store enables/replicated data,
// and lane select plus sign/zero extension for loads.
module lsu_lane_align
  import definitions::*;
(
  input  memWidth_t   width,
  input  logic [1:0]  off,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  input  logic        zext,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  b_l;
  logic [15:0] h_l;

  always_comb begin
    b_l = rdata[{off, 3'b000} +: 8];
    h_l = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be    = 4'b1111;
    wdata = sdata;
    ldata = rdata;
    unique case (width)
      BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{~zext & b_l[7]}}, b_l};
      end
      HALF: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
        ldata = {{16{~zext & h_l[15]}}, h_l};
      end
      default: begin
        be    = 4'b1111;
        wdata = sdata;
        ldata = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data bus FSM with stall.
// Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import definitions::*;
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        memRead_MEM_IN,
  input  logic        memWrite_MEM_IN,
  input  logic [2:0]  func3_MEM_IN,
  input  logic [31:0] addr_MEM_IN,
  input  logic [31:0] storeData_MEM_IN,
  output logic        stall_MEM,
  output logic [31:0] loadData_MEM_Out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_MEM_Out
`endif
);

  lsuState_t state;
  memWidth_t width_in;
  memWidth_t width_q;
  memWidth_t width_sel;
  logic [1:0]  off_q;
  logic [1:0]  off_sel;
  logic        zext_q;
  logic        zext_sel;
  logic        access;
  logic        trap;
  logic        pending;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] ldata_w;

  assign width_in = f3_width(func3_MEM_IN);
  assign access   = memRead_MEM_IN | memWrite_MEM_IN;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  always_comb begin
    mis = 1'b0;
    unique case (width_in)
      HALF:    mis = addr_MEM_IN[0];
      WORD:    mis = |addr_MEM_IN[1:0];
      default: mis = 1'b0;
    endcase
  end
  assign trap = access & mis & (state == IDLE);
  assign misalign_MEM_Out = trap;
`else
  assign trap = 1'b0;
`endif

  assign pending = access & ~trap;
  assign stall_MEM = (state == BUSY)
                   | ((state == IDLE) & pending);
  assign dmem_req = (state == BUSY);

  // Issue decode uses live inputs; the ack path
  // uses what was latched when the request went out.
  always_comb begin
    width_sel = width_in;
    off_sel   = addr_MEM_IN[1:0];
    zext_sel  = func3_MEM_IN[2];
    if (state == BUSY) begin
      width_sel = width_q;
      off_sel   = off_q;
      zext_sel  = zext_q;
    end
  end

  lsu_lane_align u_align (
    .width (width_sel),
    .off   (off_sel),
    .sdata (storeData_MEM_IN),
    .rdata (dmem_rdata),
    .zext  (zext_sel),
    .be    (be_w),
    .wdata (wdata_w),
    .ldata (ldata_w)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state            <= IDLE;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_be          <= '0;
      dmem_wdata       <= '0;
      width_q          <= BYTE;
      off_q            <= '0;
      zext_q           <= 1'b0;
      loadData_MEM_Out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending) begin
            state      <= BUSY;
            dmem_we    <= memWrite_MEM_IN;
            dmem_addr  <= {addr_MEM_IN[31:2], 2'b00};
            dmem_be    <= be_w;
            dmem_wdata <= wdata_w;
            width_q    <= width_in;
            off_q      <= addr_MEM_IN[1:0];
            zext_q     <= func3_MEM_IN[2];
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state <= DONE;
            if (!dmem_we) loadData_MEM_Out <= ldata_w;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
